// File: rtl/led_arbiter_if.sv
// Handshake bundle between the LED pattern sources and led_arbiter.
// The dim input exists only when LED_ARBITER_DIM_EN is defined.
interface led_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] pat;
  logic [NREQ-1:0]   blink;
`ifdef LED_ARBITER_DIM_EN
  logic [2:0]        dim;
`endif
  logic [NREQ-1:0]   gnt;
  logic [3:0]        led;
  logic              busy;

`ifdef LED_ARBITER_DIM_EN
  modport master (output req, pat, blink, dim, input gnt, led, busy);
  modport slave  (input req, pat, blink, dim, output gnt, led, busy);
`else
  modport master (output req, pat, blink, input gnt, led, busy);
  modport slave  (input req, pat, blink, output gnt, led, busy);
`endif
endinterface

// File: rtl/led_arbiter.sv
// Round-robin owner of the four user LEDs with min/max hold, blank gap and blink overlay.
// Defining LED_ARBITER_DIM_EN adds an 8-slot PWM brightness gate driven by bus.dim.
module led_arbiter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 100,
  parameter int NREQ     = 4,
  parameter int MIN_HOLD = 50,
  parameter int MAX_HOLD = 400,
  parameter int BLINK_HZ = 2
) (
  input  logic         clk_50mhz,
  input  logic         rst_n,
  led_arbiter_if.slave bus
);
  localparam int TICK_DIV    = CLK_FREQ / TICK_HZ;
  localparam int PRE_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_SAT    = (MAX_HOLD > MIN_HOLD) ? MAX_HOLD : MIN_HOLD;
  localparam int HOLD_W      = (HOLD_SAT > 0) ? $clog2(HOLD_SAT + 1) : 1;
  localparam int BLINK_TICKS = TICK_HZ / (2 * BLINK_HZ);
  localparam int BLK_W       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int IDX_W       = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SHOW, LINGER, GAP} state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  owner_r;
  logic [IDX_W-1:0]  ptr_r;
  logic [PRE_W-1:0]  presc_r;
  logic [HOLD_W-1:0] hold_r;
  logic [BLK_W-1:0]  blk_cnt_r;
  logic              phase_r;
  logic [NREQ-1:0]   gnt_r;
  logic [3:0]        led_r;
  logic              busy_r;
  logic [3:0]        shown_r;

  logic              tick_s;
  logic              blk_wrap_s;
  logic [HOLD_W-1:0] hold_inc_s;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic [IDX_W-1:0]  pick_s;
  logic [IDX_W-1:0]  ptr_nxt_s;
  logic              own_req_s;
  logic              others_s;
  logic [3:0]        show_val_s;
  logic [3:0]        pwm_mask_s;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Later (lower) offsets overwrite earlier ones, so the nearest requester above ptr wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    sel = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(p) + i) % NREQ);
      sel  = r[cand] ? cand : sel;
    end
    return sel;
  endfunction

  assign tick_s     = (presc_r == PRE_W'(TICK_DIV - 1));
  assign blk_wrap_s = tick_s && (blk_cnt_r == BLK_W'(BLINK_TICKS - 1));
  assign hold_inc_s = (hold_r == HOLD_W'(HOLD_SAT)) ? hold_r : hold_r + HOLD_W'(1);
  assign hold_nxt_s = tick_s ? hold_inc_s : hold_r;
  assign pick_s     = rr_pick(bus.req, ptr_r);
  assign ptr_nxt_s  = (owner_r == IDX_W'(NREQ - 1)) ? IDX_W'(0) : owner_r + IDX_W'(1);
  assign own_req_s  = bus.req[owner_r];
  assign others_s   = |(bus.req & ~onehot(owner_r));
  assign show_val_s = bus.pat[{owner_r, 2'b00} +: 4] & ((bus.blink[owner_r] && !phase_r) ? 4'h0 : 4'hF);

`ifdef LED_ARBITER_DIM_EN
  localparam int SLOT_RAW = CLK_FREQ / (TICK_HZ * 64);
  localparam int SLOT_DIV = (SLOT_RAW < 1) ? 1 : SLOT_RAW;
  localparam int SLOT_W   = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;

  logic [SLOT_W-1:0] slot_div_r;
  logic [2:0]        slot_r;

  // PWM slot sequencer: eight slots of SLOT_DIV cycles each.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      slot_div_r <= SLOT_W'(0);
      slot_r     <= 3'd0;
    end else if (slot_div_r == SLOT_W'(SLOT_DIV - 1)) begin
      slot_div_r <= SLOT_W'(0);
      slot_r     <= slot_r + 3'd1;
    end else begin
      slot_div_r <= slot_div_r + SLOT_W'(1);
    end
  end

  assign pwm_mask_s = (slot_r <= bus.dim) ? 4'hF : 4'h0;
`else
  assign pwm_mask_s = 4'hF;
`endif

  // Arbitration FSM with prescaler, hold/blink counters and registered outputs.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      owner_r   <= IDX_W'(0);
      ptr_r     <= IDX_W'(0);
      presc_r   <= PRE_W'(0);
      hold_r    <= HOLD_W'(0);
      blk_cnt_r <= BLK_W'(0);
      phase_r   <= 1'b1;
      gnt_r     <= {NREQ{1'b0}};
      led_r     <= 4'h0;
      busy_r    <= 1'b0;
      shown_r   <= 4'h0;
    end else begin
      presc_r <= tick_s ? PRE_W'(0) : presc_r + PRE_W'(1);
      if (state_r == SHOW || state_r == LINGER) begin
        hold_r <= hold_nxt_s;
        if (blk_wrap_s) begin
          blk_cnt_r <= BLK_W'(0);
          phase_r   <= ~phase_r;
        end else if (tick_s) begin
          blk_cnt_r <= blk_cnt_r + BLK_W'(1);
        end
      end
      case (state_r)
        IDLE: begin
          led_r <= 4'h0;
          if (|bus.req) begin
            owner_r   <= pick_s;
            gnt_r     <= onehot(pick_s);
            busy_r    <= 1'b1;
            hold_r    <= HOLD_W'(0);
            blk_cnt_r <= BLK_W'(0);
            phase_r   <= 1'b1;
            state_r   <= SHOW;
          end else begin
            gnt_r  <= {NREQ{1'b0}};
            busy_r <= 1'b0;
          end
        end
        SHOW: begin
          if (!own_req_s && (hold_r < HOLD_W'(MIN_HOLD))) begin
            state_r <= LINGER;
            led_r   <= shown_r & pwm_mask_s;
          end else if (!own_req_s ||
                       ((MAX_HOLD != 0) && (hold_r >= HOLD_W'(MAX_HOLD)) && others_s)) begin
            state_r <= GAP;
            ptr_r   <= ptr_nxt_s;
            gnt_r   <= {NREQ{1'b0}};
            led_r   <= 4'h0;
            busy_r  <= 1'b0;
          end else begin
            shown_r <= show_val_s;
            led_r   <= show_val_s & pwm_mask_s;
          end
        end
        LINGER: begin
          if (own_req_s) begin
            state_r <= SHOW;
            led_r   <= shown_r & pwm_mask_s;
          end else if (tick_s && (hold_inc_s >= HOLD_W'(MIN_HOLD))) begin
            state_r <= GAP;
            ptr_r   <= ptr_nxt_s;
            gnt_r   <= {NREQ{1'b0}};
            led_r   <= 4'h0;
            busy_r  <= 1'b0;
          end else begin
            led_r <= shown_r & pwm_mask_s;
          end
        end
        GAP: begin
          gnt_r  <= {NREQ{1'b0}};
          led_r  <= 4'h0;
          busy_r <= 1'b0;
          if (tick_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= {NREQ{1'b0}};
          led_r   <= 4'h0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.led  = led_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter: vector table plus multi-cycle sequences,
// expectations queued at drive time and compared one cycle later.
module tb_led_arbiter;
  logic clk_50mhz = 1'b0;
  logic rst_n;

  always #5 clk_50mhz = ~clk_50mhz;

  led_arbiter_if #(.NREQ(4)) bus ();

  led_arbiter #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .NREQ    (4),
    .MIN_HOLD(5),
    .MAX_HOLD(8),
    .BLINK_HZ(25)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] led;
    logic       busy;
    string      tag;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  blink;
    logic [3:0]  gnt;
    logic [3:0]  led;
    logic        busy;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] p,
                      input logic [3:0] bl, input logic [3:0] eg, input logic [3:0] el,
                      input logic eb, input string tag);
    exp_t e;
    exp_t got;
    rst_n     = r;
    bus.req   = rq;
    bus.pat   = p;
    bus.blink = bl;
    e.gnt = eg;
    e.led = el;
    e.busy = eb;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk_50mhz);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      got = sb_q.pop_front();
      chk({got.tag, ".gnt"}, bus.gnt, got.gnt);
      chk({got.tag, ".led"}, bus.led, got.led);
      chk({got.tag, ".busy"}, {3'b000, bus.busy}, {3'b000, got.busy});
    end
  endtask

  task automatic do_reset(input logic [3:0] rq, input logic [15:0] p, input logic [3:0] bl);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, rq, p, bl, 4'b0000, 4'h0, 1'b0, "reset");
    end
  endtask

  vec_t tbl[11];

  initial begin
    logic [3:0]  rq;
    logic [3:0]  eg;
    logic [3:0]  el;
    logic [15:0] pt;
    int          ph;
    int          ow;

    rst_n     = 1'b0;
    bus.req   = 4'b0000;
    bus.pat   = 16'h0000;
    bus.blink = 4'b0000;
`ifdef LED_ARBITER_DIM_EN
    bus.dim   = 3'd7;
`endif

    // rst, req, pat, blink -> gnt, led, busy
    tbl[0]  = '{1'b0, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 16'h0000, 4'b0000, 4'b0000, 4'h0, 1'b0};
    tbl[3]  = '{1'b1, 4'b1111, 16'h0000, 4'b0000, 4'b0001, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0100, 16'h0A00, 4'b0000, 4'b0000, 4'h0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0100, 16'h0A00, 4'b0000, 4'b0100, 4'h0, 1'b1};
    tbl[6]  = '{1'b1, 4'b0100, 16'h0A00, 4'b0000, 4'b0100, 4'hA, 1'b1};
    tbl[7]  = '{1'b1, 4'b0100, 16'h0500, 4'b0000, 4'b0100, 4'h5, 1'b1};
    tbl[8]  = '{1'b1, 4'b0100, 16'hF5F0, 4'b1011, 4'b0100, 4'h5, 1'b1};
    tbl[9]  = '{1'b1, 4'b0111, 16'hF5F0, 4'b1011, 4'b0100, 4'h5, 1'b1};
    tbl[10] = '{1'b1, 4'b0111, 16'h0300, 4'b1011, 4'b0100, 4'h3, 1'b1};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].pat, tbl[i].blink,
           tbl[i].gnt, tbl[i].led, tbl[i].busy, $sformatf("tbl%0d", i));
    end

    // Minimum hold: owner 1 drops after two ticks, lingers to hold=5, gap, then RR from 2.
    do_reset(4'b0010, 16'h00C0, 4'b0000);
    for (int k = 1; k <= 65; k++) begin
      rq = (k <= 20) ? 4'b0010 : ((k <= 50) ? 4'b0000 : 4'b1110);
      pt = (k <= 20) ? 16'h00C0 : 16'h0730;
      eg = (k <= 49) ? 4'b0010 : ((k <= 60) ? 4'b0000 : 4'b0100);
      if (k == 1 || (k >= 50 && k <= 61)) el = 4'h0;
      else if (k <= 49) el = 4'hC;
      else el = 4'h7;
      step(1'b1, rq, pt, 4'b0000, eg, el, |eg, "minhold");
    end

    // Rotation between owners 0 and 3 every 8 ticks, then reset while owner 3 shows.
    do_reset(4'b1001, 16'h9006, 4'b0000);
    for (int k = 1; k <= 284; k++) begin
      ph = (k - 1) % 90;
      ow = ((k - 1) / 90) % 2;
      eg = (ph <= 79) ? ((ow == 1) ? 4'b1000 : 4'b0001) : 4'b0000;
      el = (ph >= 1 && ph <= 79) ? ((ow == 1) ? 4'h9 : 4'h6) : 4'h0;
      step(1'b1, 4'b1001, 16'h9006, 4'b0000, eg, el, |eg, "rotate");
    end
    step(1'b0, 4'b1111, 16'h9006, 4'b0000, 4'b0000, 4'h0, 1'b0, "midrst");
    step(1'b1, 4'b1111, 16'h9006, 4'b0000, 4'b0001, 4'h0, 1'b1, "postrst");
    step(1'b1, 4'b1111, 16'h9006, 4'b0000, 4'b0001, 4'h6, 1'b1, "postrst_led");

    // Blink: two ticks on, two ticks off, starting on.
    do_reset(4'b0001, 16'h000F, 4'b0001);
    for (int k = 1; k <= 100; k++) begin
      if (k == 1) el = 4'h0;
      else if (((k - 1) / 20) % 2 == 0) el = 4'hF;
      else el = 4'h0;
      step(1'b1, 4'b0001, 16'h000F, 4'b0001, 4'b0001, el, 1'b1, "blink");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the board's 4 user LEDs (LED15:LED12) between NREQ requesters: pattern generator, error-code display, heartbeat, debug override.
- Round-robin grant with a minimum display time, a maximum hold time, a one-tick blank gap between owners, and an optional per-owner blink overlay.
- Sits between the LED pattern sources and the LED pins; all sources run on the 50 MHz board clock.

Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- TICK_HZ, 100: scheduler tick rate; one tick is CLK_FREQ/TICK_HZ cycles.
- NREQ, 4: number of requesters, 2..8.
- MIN_HOLD, 50: minimum ticks a granted owner stays displayed.
- MAX_HOLD, 400: ticks after which the owner is rotated out if another request is pending. 0 disables rotation.
- BLINK_HZ, 2: blink overlay frequency. TICK_HZ/(2*BLINK_HZ) must be an integer ≥1.

Ports:
- clk_50mhz  in   1       board clock, 50 MHz.
- rst_n      in   1       reset, synchronous, active-low.
- req        in   NREQ    level request per requester.
- pat        in   4*NREQ  requester i pattern on bits [4i+3:4i].
- blink      in   NREQ    requester i wants its pattern blinked.
- gnt        out  NREQ    one-hot grant, registered.
- led        out  4       LED drive, registered, 1 = on.
- busy       out  1       high whenever gnt is nonzero.

Behaviour:
- Reset: rst_n is sampled low on a clk_50mhz edge. At that edge:
  - gnt=0, led=0, busy=0.
  - State = IDLE; RR pointer = 0.
  - Prescaler, hold counter and blink counter are cleared.
  - Blink phase = on.
- Reset mid-grant aborts the grant immediately; no gap state.
- Prescaler: a one-cycle tick pulse every CLK_FREQ/TICK_HZ cycles. It free-runs from reset.
- IDLE:
  - led=0.
  - If any req bit is set, grant the first set bit searching upward (with wrap) from the RR pointer.
  - gnt is valid the next cycle; go to SHOW.
  - The hold counter clears on grant; blink phase = on.
- SHOW:
  - led <= pat[owner] each cycle. If blink[owner]=1, led <= pat[owner] & {4{phase}}.
  - Latency from pat change to led: 1 cycle.
  - The hold counter increments on each tick and saturates.
  - Phase toggles every TICK_HZ/(2*BLINK_HZ) ticks.
  - Owner drops req with hold < MIN_HOLD: go to LINGER.
  - Owner drops req with hold ≥ MIN_HOLD: go to GAP.
  - MAX_HOLD≠0, hold ≥ MAX_HOLD, and any other req set: go to GAP. Otherwise keep the grant indefinitely.
  - Requests from non-owners never preempt before MAX_HOLD.
- LINGER:
  - gnt is held; led is frozen at its last value; blink keeps toggling if it was active.
  - Go to GAP on the tick where hold reaches MIN_HOLD.
  - Owner re-asserts req during LINGER: return to SHOW. The hold count continues, not reset.
- GAP:
  - gnt=0, led=0, busy=0.
  - RR pointer = owner+1 mod NREQ.
  - Stay until the next tick pulse, then go to IDLE.
  - Gap length is 1..CLK_FREQ/TICK_HZ cycles.
- Simultaneous requests resolve by RR order only; the lowest index wins from pointer 0.
- pat and blink of non-owners are ignored.
- Counter widths are sized with $clog2 from the parameters; no overflow wraps.

Optional Feature:
- Macro: LED_ARBITER_DIM_EN.
- Defined:
  - Adds input port dim [2:0] after blink.
  - An 8-slot PWM, with slot width CLK_FREQ/(TICK_HZ*64) cycles (minimum 1), gates led.
  - LEDs are on during slots 0..dim; dim=7 is full brightness.
  - Applied after the blink mask; reset clears the PWM counter.
- Undefined: no dim port; led is driven ungated.

Test Plan (sim params CLK_FREQ=1000, TICK_HZ=100, so 10 cycles/tick; NREQ=4, MIN_HOLD=5, MAX_HOLD=8, BLINK_HZ=25):
- Reset: rst_n=0 for 3 cycles, req=4'b1111 -> gnt=0, led=0, busy=0 throughout. First edge with rst_n=1 -> gnt=4'b0001 on the following cycle.
- Single request: req=4'b0100, pat[11:8]=4'hA, blink=0 -> gnt=4'b0100 one cycle later, led=4'hA one cycle after that. Changing pat to 4'h5 gives led=4'h5 after 1 cycle.
- Minimum hold: req[1] granted, dropped after 2 ticks -> gnt stays 4'b0010 and led frozen until hold=5. Then gnt=0, led=0 until the next tick, then IDLE.
- Rotation: req=4'b1001 steady -> owner 0 for 8 ticks, gap, owner 3 for 8 ticks, gap, owner 0 again. Never two gnt bits set.
- Blink: req[0]=1, pat[3:0]=4'hF, blink[0]=1 -> led F for 2 ticks, 0 for 2 ticks, repeating, starting on.
- Reset mid-grant: during owner 3 SHOW, rst_n=0 for 1 cycle, req=4'b1111 -> gnt=0, led=0 at that edge, then gnt=4'b0001 (pointer back to 0).
